ts_packet_aligner: RTL
======================

// Module: ts_packet_aligner
// PURPOSE
//  Receive-side consumer of the 9-bit {sync,data} byte stream produced by the output FIFO path.
//  Hunts for and locks onto 188-byte MPEG-2 TS packet boundaries and re-emits locked packets.
//  Marks packets with SOP/EOP, extracts PID and TEI, and keeps packet and sync-error counters.
//  Sits in the read-clock domain, directly after the FIFO read side and ahead of the QoS monitors.
// PARAMETERS
//  PKT_LEN     188    bytes per TS packet
//  SYNC_BYTE   8'h47  required value of the sync byte
//  LOCK_CNT    3      consecutive good syncs needed to reach LOCK (>=1)
//  UNLOCK_CNT  3      consecutive bad syncs in LOCK that force a return to HUNT (>=1)
//  CNT_WIDTH   16     width of the saturating counters
// PORTS
//  clk           in   1          single clock; all logic runs on rising edge
//  rstn          in   1          asynchronous active-low reset
//  valid_in      in   1          data_in carries a byte this cycle
//  data_in       in   9          [8] upstream sync flag, [7:0] TS byte
//  out_valid     out  1          out_data valid (locked packet byte)
//  out_data      out  8          TS byte
//  out_sop       out  1          with out_valid: first byte of packet
//  out_eop       out  1          with out_valid: byte PKT_LEN-1 of packet
//  locked        out  1          state == LOCK
//  pid           out  13         PID of current packet, held until next update
//  tei           out  1          transport_error_indicator of current packet
//  pid_valid     out  1          one-cycle pulse when pid/tei update
//  pkt_cnt       out  CNT_WIDTH  count of complete packets output; saturating
//  sync_err_cnt  out  CNT_WIDTH  count of bad syncs seen in LOCK; saturating
// BEHAVIOUR
//  Reset: state=HUNT, byte_cnt=0; every output 0.
//  Only cycles with valid_in=1 advance anything. Gaps of any length are transparent.
//  candidate = data_in[8] && data_in[7:0]==SYNC_BYTE.
//  good sync = candidate at byte_cnt==0. Bad sync = anything else at byte_cnt==0.
//  byte_cnt runs 0..PKT_LEN-1 and wraps to 0.
//  HUNT: byte_cnt unused, nothing output.
//   - On candidate: go to VERIFY, byte_cnt=1, good_run=1.
//   - If LOCK_CNT==1: go directly to LOCK, and this byte is output with SOP.
//  VERIFY: at byte_cnt==0:
//   - good sync: good_run++. If good_run reaches LOCK_CNT, go to LOCK; this byte is output with SOP.
//   - bad sync: go to HUNT, and the same byte is re-evaluated as in HUNT
//     (a candidate restarts VERIFY with byte_cnt=1).
//  LOCK: every accepted byte is output. At byte_cnt==0:
//   - good sync: bad_run=0.
//   - bad sync: bad_run++ and sync_err_cnt++.
//   - When bad_run reaches UNLOCK_CNT: go to HUNT; the triggering byte is NOT output;
//     bad_run=0; the byte is re-evaluated as in HUNT.
//   - The sync flag at byte_cnt!=0 is ignored in LOCK.
//  Outputs are registered, one clk after acceptance.
//   - out_sop = output byte with byte_cnt==0.
//   - out_eop = output byte with byte_cnt==PKT_LEN-1.
//  PID:
//   - byte 1 (byte_cnt==1): capture tei=byte[7] and pid[12:8]=byte[4:0].
//   - byte 2 (byte_cnt==2): capture pid[7:0].
//   - pid/tei update and pid_valid pulses in the same cycle as out_valid for byte 2. LOCK only.
//  pkt_cnt increments on each out_eop. Both counters stick at all-ones.
//  Output packets are always complete: LOCK exits only at byte_cnt==0, right after an EOP.
//  Async reset mid-packet: immediate return to reset state.
//   - Packet resumes only after a fresh HUNT→LOCK sequence.
// TESTING
//  1) 5 clean packets {1,47},{0,41},{0,00},... LOCK_CNT=3:
//     -> locked rises with 3rd sync; packets 3-5 output; SOP/EOP correct; pkt_cnt=3.
//  2) Packet header 47 41 00: pid_valid pulse, pid=13'h0100, tei=0.
//     Header 47 9F FF: pid=13'h1FFF, tei=1.
//  3) In LOCK, one sync byte 0x46:
//     -> sync_err_cnt=1, locked stays 1, packet still output.
//     3 consecutive bad syncs -> locked=0 at 3rd; that byte not output.
//  4) Random valid_in gaps (~50% duty) on scenario 1 -> identical output byte sequence and flags.
//  5) Flagged 0x47 at byte 100 during VERIFY, true syncs aligned elsewhere:
//     -> bad sync returns FSM to HUNT, and lock is achieved on the true alignment.
//  6) rstn low at byte 90 of a locked packet -> all outputs 0 at once;
//     after release, out_valid stays 0 until a new lock.

Source files
------------

// File: rtl/ts_packet_aligner.sv
// MPEG-2 TS packet aligner: hunts for 188-byte packet boundaries in a {sync,data} byte stream,
// locks after LOCK_CNT good syncs, re-emits locked packets with SOP/EOP, PID/TEI and counters.
module ts_packet_aligner #(
  parameter int         PKT_LEN    = 188,
  parameter logic [7:0] SYNC_BYTE  = 8'h47,
  parameter int         LOCK_CNT   = 3,
  parameter int         UNLOCK_CNT = 3,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 valid_in,
  input  logic [8:0]           data_in,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 locked,
  output logic [12:0]          pid,
  output logic                 tei,
  output logic                 pid_valid,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] sync_err_cnt,
  output logic [1:0]           fsm_state
);

  localparam int BW = $clog2(PKT_LEN);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(UNLOCK_CNT + 1);
  localparam logic [BW-1:0] PKT_LAST    = BW'(PKT_LEN - 1);
  localparam logic [GW-1:0] LOCK_LAST   = GW'(LOCK_CNT - 1);
  localparam logic [RW-1:0] UNLOCK_LAST = RW'(UNLOCK_CNT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] byte_cnt, byte_cnt_nxt;
  logic [GW-1:0] good_run, good_run_nxt;
  logic [RW-1:0] bad_run, bad_run_nxt;
  logic          candidate;
  logic          at_sync;
  logic [BW-1:0] cnt_inc;
  logic          emit;
  logic          err_inc;
  logic          hunt_eval;
  logic [4:0]    pid_hi;
  logic          tei_hold;

  assign candidate = data_in[8] && (data_in[7:0] == SYNC_BYTE);
  assign at_sync   = (byte_cnt == '0);
  assign cnt_inc   = (byte_cnt == PKT_LAST) ? '0 : byte_cnt + 1'b1;
  assign locked    = (state == LOCK);
  assign fsm_state = state;

  // hunt_eval covers both HUNT proper and a byte that just knocked VERIFY/LOCK back to HUNT,
  // so the same byte is judged once more as a potential new sync.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    good_run_nxt = good_run;
    bad_run_nxt  = bad_run;
    emit         = 1'b0;
    err_inc      = 1'b0;
    hunt_eval    = 1'b0;
    if (valid_in) begin
      case (state)
        HUNT: hunt_eval = 1'b1;
        VERIFY: begin
          if (!at_sync) begin
            byte_cnt_nxt = cnt_inc;
          end else if (candidate) begin
            byte_cnt_nxt = cnt_inc;
            good_run_nxt = good_run + 1'b1;
            if (good_run == LOCK_LAST) begin
              state_nxt   = LOCK;
              bad_run_nxt = '0;
              emit        = 1'b1;
            end
          end else begin
            hunt_eval = 1'b1;
          end
        end
        LOCK: begin
          byte_cnt_nxt = cnt_inc;
          emit         = 1'b1;
          if (at_sync) begin
            if (candidate) begin
              bad_run_nxt = '0;
            end else begin
              err_inc = 1'b1;
              if (bad_run == UNLOCK_LAST) begin
                emit        = 1'b0;
                bad_run_nxt = '0;
                hunt_eval   = 1'b1;
              end else begin
                bad_run_nxt = bad_run + 1'b1;
              end
            end
          end
        end
        default: state_nxt = HUNT;
      endcase

      if (hunt_eval) begin
        if (candidate) begin
          byte_cnt_nxt = BW'(1);
          good_run_nxt = GW'(1);
          bad_run_nxt  = '0;
          if (LOCK_CNT == 1) begin
            state_nxt = LOCK;
            emit      = 1'b1;
          end else begin
            state_nxt = VERIFY;
          end
        end else begin
          state_nxt    = HUNT;
          byte_cnt_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= HUNT;
      byte_cnt <= '0;
      good_run <= '0;
      bad_run  <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      good_run <= good_run_nxt;
      bad_run  <= bad_run_nxt;
    end
  end

  // Emitted bytes always sit at byte_cnt of the accepted byte (0 in HUNT), so SOP/EOP
  // and the PID byte positions come straight from the current count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      pid          <= '0;
      tei          <= 1'b0;
      pid_valid    <= 1'b0;
      pid_hi       <= '0;
      tei_hold     <= 1'b0;
      pkt_cnt      <= '0;
      sync_err_cnt <= '0;
    end else begin
      out_valid <= emit;
      out_sop   <= emit && (byte_cnt == '0);
      out_eop   <= emit && (byte_cnt == PKT_LAST);
      pid_valid <= emit && (byte_cnt == BW'(2));
      if (emit) begin
        out_data <= data_in[7:0];
      end
      if (emit && (byte_cnt == BW'(1))) begin
        tei_hold <= data_in[7];
        pid_hi   <= data_in[4:0];
      end
      if (emit && (byte_cnt == BW'(2))) begin
        pid <= {pid_hi, data_in[7:0]};
        tei <= tei_hold;
      end
      if (emit && (byte_cnt == PKT_LAST) && (pkt_cnt != '1)) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      if (err_inc && (sync_err_cnt != '1)) begin
        sync_err_cnt <= sync_err_cnt + 1'b1;
      end
    end
  end

endmodule
